// File: rtl/axi_apb_master.sv
// APB master that serves a write-command and a read-command FIFO, one transfer at a time,
// with round-robin arbitration, an optional ACCESS-phase timeout and registered APB/response outputs.
module axi_apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    wr_cmd_valid,
    output logic                    wr_cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   wr_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   wr_cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] wr_cmd_wstrb,
    input  logic                    rd_cmd_valid,
    output logic                    rd_cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   rd_cmd_addr,
    output logic                    wr_rsp_valid,
    input  logic                    wr_rsp_ready,
    output logic                    wr_rsp_error,
    output logic                    rd_rsp_valid,
    input  logic                    rd_rsp_ready,
    output logic [DATA_WIDTH-1:0]   rd_rsp_rdata,
    output logic                    rd_rsp_error,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [2:0]              PPROT,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [SW-1:0]         pstrb_q, pstrb_d;
    logic                  wr_rsp_valid_q, wr_rsp_valid_d;
    logic                  wr_rsp_error_q, wr_rsp_error_d;
    logic                  rd_rsp_valid_q, rd_rsp_valid_d;
    logic                  rd_rsp_error_q, rd_rsp_error_d;
    logic [DATA_WIDTH-1:0] rd_rsp_rdata_q, rd_rsp_rdata_d;
    logic                  last_wr_q, last_wr_d;
    logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;

    logic grant_wr, grant_rd, timeout, rsp_done;

    // last_wr_q == 0 after reset, so the first contested grant goes to the write side.
    assign grant_wr = PRESETn && (state_q == IDLE) && wr_cmd_valid && (!rd_cmd_valid || !last_wr_q);
    assign grant_rd = PRESETn && (state_q == IDLE) && rd_cmd_valid && !grant_wr;
    assign timeout  = (TIMEOUT_CYCLES > 0) && !PREADY && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign rsp_done = (wr_rsp_valid_q && wr_rsp_ready) || (rd_rsp_valid_q && rd_rsp_ready);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q        <= IDLE;
            paddr_q        <= '0;
            psel_q         <= 1'b0;
            penable_q      <= 1'b0;
            pwrite_q       <= 1'b0;
            pwdata_q       <= '0;
            pstrb_q        <= '0;
            wr_rsp_valid_q <= 1'b0;
            wr_rsp_error_q <= 1'b0;
            rd_rsp_valid_q <= 1'b0;
            rd_rsp_error_q <= 1'b0;
            rd_rsp_rdata_q <= '0;
            last_wr_q      <= 1'b0;
            tmo_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            paddr_q        <= paddr_d;
            psel_q         <= psel_d;
            penable_q      <= penable_d;
            pwrite_q       <= pwrite_d;
            pwdata_q       <= pwdata_d;
            pstrb_q        <= pstrb_d;
            wr_rsp_valid_q <= wr_rsp_valid_d;
            wr_rsp_error_q <= wr_rsp_error_d;
            rd_rsp_valid_q <= rd_rsp_valid_d;
            rd_rsp_error_q <= rd_rsp_error_d;
            rd_rsp_rdata_q <= rd_rsp_rdata_d;
            last_wr_q      <= last_wr_d;
            tmo_cnt_q      <= tmo_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_wr || grant_rd) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (PREADY || timeout) state_d = RESP;
            RESP:    if (rsp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_cmd_ready   = 1'b0;
        rd_cmd_ready   = 1'b0;
        paddr_d        = paddr_q;
        psel_d         = psel_q;
        penable_d      = penable_q;
        pwrite_d       = pwrite_q;
        pwdata_d       = pwdata_q;
        pstrb_d        = pstrb_q;
        wr_rsp_valid_d = wr_rsp_valid_q;
        wr_rsp_error_d = wr_rsp_error_q;
        rd_rsp_valid_d = rd_rsp_valid_q;
        rd_rsp_error_d = rd_rsp_error_q;
        rd_rsp_rdata_d = rd_rsp_rdata_q;
        last_wr_d      = last_wr_q;
        tmo_cnt_d      = (state_q == ACCESS) ? tmo_cnt_q + TW'(1) : '0;
        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    wr_cmd_ready = 1'b1;
                    paddr_d      = wr_cmd_addr;
                    pwrite_d     = 1'b1;
                    pwdata_d     = wr_cmd_wdata;
                    pstrb_d      = wr_cmd_wstrb;
                    psel_d       = 1'b1;
                    penable_d    = 1'b0;
                    last_wr_d    = 1'b1;
                end else if (grant_rd) begin
                    rd_cmd_ready = 1'b1;
                    paddr_d      = rd_cmd_addr;
                    pwrite_d     = 1'b0;
                    pwdata_d     = '0;
                    pstrb_d      = '0;
                    psel_d       = 1'b1;
                    penable_d    = 1'b0;
                    last_wr_d    = 1'b0;
                end
            end
            SETUP: penable_d = 1'b1;
            ACCESS: begin
                // A timeout reports as an error with zeroed read data.
                if (PREADY || timeout) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    if (pwrite_q) begin
                        wr_rsp_valid_d = 1'b1;
                        wr_rsp_error_d = PREADY ? PSLVERR : 1'b1;
                    end else begin
                        rd_rsp_valid_d = 1'b1;
                        rd_rsp_error_d = PREADY ? PSLVERR : 1'b1;
                        rd_rsp_rdata_d = PREADY ? PRDATA : '0;
                    end
                end
            end
            RESP: begin
                if (wr_rsp_valid_q && wr_rsp_ready) wr_rsp_valid_d = 1'b0;
                if (rd_rsp_valid_q && rd_rsp_ready) rd_rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign PADDR        = paddr_q;
    assign PSEL         = psel_q;
    assign PENABLE      = penable_q;
    assign PWRITE       = pwrite_q;
    assign PWDATA       = pwdata_q;
    assign PSTRB        = pstrb_q;
    assign PPROT        = 3'b000;
    assign wr_rsp_valid = wr_rsp_valid_q;
    assign wr_rsp_error = wr_rsp_error_q;
    assign rd_rsp_valid = rd_rsp_valid_q;
    assign rd_rsp_error = rd_rsp_error_q;
    assign rd_rsp_rdata = rd_rsp_rdata_q;
endmodule

// File: tb/tb_axi_apb_master.sv
// Directed bench for axi_apb_master: inputs change on the falling edge, outputs are checked 1ns later.
module tb_axi_apb_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          wr_cmd_valid, wr_cmd_ready;
    logic [AW-1:0] wr_cmd_addr;
    logic [DW-1:0] wr_cmd_wdata;
    logic [SW-1:0] wr_cmd_wstrb;
    logic          rd_cmd_valid, rd_cmd_ready;
    logic [AW-1:0] rd_cmd_addr;
    logic          wr_rsp_valid, wr_rsp_ready, wr_rsp_error;
    logic          rd_rsp_valid, rd_rsp_ready, rd_rsp_error;
    logic [DW-1:0] rd_rsp_rdata;
    logic [AW-1:0] PADDR;
    logic          PSEL, PENABLE, PWRITE;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic [2:0]    PPROT;
    logic [DW-1:0] PRDATA;
    logic          PREADY, PSLVERR;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 PCLK = ~PCLK;

    axi_apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_cmd_addr(wr_cmd_addr),
        .wr_cmd_wdata(wr_cmd_wdata), .wr_cmd_wstrb(wr_cmd_wstrb),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_addr(rd_cmd_addr),
        .wr_rsp_valid(wr_rsp_valid), .wr_rsp_ready(wr_rsp_ready), .wr_rsp_error(wr_rsp_error),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_rdata(rd_rsp_rdata),
        .rd_rsp_error(rd_rsp_error),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge PCLK);
    endtask

    initial begin
        int wr_left, rd_left;
        logic exp_wr;
        PRESETn = 1'b0;
        wr_cmd_valid = 0; wr_cmd_addr = '0; wr_cmd_wdata = '0; wr_cmd_wstrb = '0;
        rd_cmd_valid = 0; rd_cmd_addr = '0;
        wr_rsp_ready = 0; rd_rsp_ready = 0;
        PRDATA = '0; PREADY = 0; PSLVERR = 0;

        // Reset state
        tick(); tick(); #1;
        chk("rst_psel", PSEL, 0);       chk("rst_penable", PENABLE, 0);
        chk("rst_paddr", PADDR, 0);     chk("rst_pwrite", PWRITE, 0);
        chk("rst_pwdata", PWDATA, 0);   chk("rst_pstrb", PSTRB, 0);
        chk("rst_pprot", PPROT, 0);     chk("rst_wr_rsp_valid", wr_rsp_valid, 0);
        chk("rst_rd_rsp_valid", rd_rsp_valid, 0);
        chk("rst_rdata", rd_rsp_rdata, 0);
        chk("rst_wr_err", wr_rsp_error, 0); chk("rst_rd_err", rd_rsp_error, 0);
        chk("rst_wr_cmd_ready", wr_cmd_ready, 0); chk("rst_rd_cmd_ready", rd_cmd_ready, 0);
        tick(); PRESETn = 1'b1;

        // Minimum-latency write
        tick();
        wr_cmd_valid = 1; wr_cmd_addr = 32'h10; wr_cmd_wdata = 32'hDEADBEEF; wr_cmd_wstrb = 4'hF;
        PREADY = 1; wr_rsp_ready = 1; rd_rsp_ready = 1; #1;
        chk("w1_pop", wr_cmd_ready, 1); chk("w1_no_rd_pop", rd_cmd_ready, 0);
        tick(); wr_cmd_valid = 0; #1;
        chk("w1_setup_psel", PSEL, 1); chk("w1_setup_penable", PENABLE, 0);
        chk("w1_pwrite", PWRITE, 1);   chk("w1_paddr", PADDR, 32'h10);
        chk("w1_pwdata", PWDATA, 32'hDEADBEEF); chk("w1_pstrb", PSTRB, 4'hF);
        chk("w1_ready_low", wr_cmd_ready, 0);
        tick(); #1;
        chk("w1_access_psel", PSEL, 1); chk("w1_access_penable", PENABLE, 1);
        tick(); #1;
        chk("w1_rsp_valid", wr_rsp_valid, 1); chk("w1_rsp_err", wr_rsp_error, 0);
        chk("w1_psel_drop", PSEL, 0); chk("w1_penable_drop", PENABLE, 0);
        chk("w1_no_rd_rsp", rd_rsp_valid, 0);
        tick(); #1;
        chk("w1_rsp_done", wr_rsp_valid, 0);

        // Read with three wait states
        tick(); rd_cmd_valid = 1; rd_cmd_addr = 32'h20; PREADY = 0; #1;
        chk("r1_pop", rd_cmd_ready, 1); chk("r1_no_wr_pop", wr_cmd_ready, 0);
        tick(); rd_cmd_valid = 0; #1;
        chk("r1_setup_penable", PENABLE, 0); chk("r1_pwrite", PWRITE, 0);
        chk("r1_paddr", PADDR, 32'h20); chk("r1_pstrb", PSTRB, 0); chk("r1_pwdata", PWDATA, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("r1_wait_penable", PENABLE, 1); chk("r1_wait_paddr", PADDR, 32'h20);
            chk("r1_wait_no_rsp", rd_rsp_valid, 0);
        end
        tick(); PREADY = 1; PRDATA = 32'h12345678; #1;
        chk("r1_last_penable", PENABLE, 1); chk("r1_last_paddr", PADDR, 32'h20);
        tick(); #1;
        chk("r1_rsp_valid", rd_rsp_valid, 1); chk("r1_rdata", rd_rsp_rdata, 32'h12345678);
        chk("r1_rsp_err", rd_rsp_error, 0); chk("r1_psel_drop", PSEL, 0);
        tick(); #1;
        chk("r1_rsp_done", rd_rsp_valid, 0);

        // Read with PSLVERR and a stalled response FIFO
        tick();
        rd_cmd_valid = 1; rd_cmd_addr = 32'h30; PREADY = 1; PSLVERR = 1;
        PRDATA = 32'hCAFEF00D; rd_rsp_ready = 0; #1;
        chk("r2_pop", rd_cmd_ready, 1);
        tick();
        rd_cmd_valid = 0; wr_cmd_valid = 1; wr_cmd_addr = 32'h34;
        wr_cmd_wdata = 32'h55AA55AA; wr_cmd_wstrb = 4'h3; #1;
        chk("r2_setup_no_pop", wr_cmd_ready, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick(); PSLVERR = 0; PRDATA = 32'h0; #1;
            chk("r2_hold_valid", rd_rsp_valid, 1); chk("r2_hold_rdata", rd_rsp_rdata, 32'hCAFEF00D);
            chk("r2_hold_err", rd_rsp_error, 1); chk("r2_hold_no_pop", wr_cmd_ready, 0);
            chk("r2_hold_no_wr_rsp", wr_rsp_valid, 0);
        end
        tick(); rd_rsp_ready = 1; #1;
        chk("r2_handshake_valid", rd_rsp_valid, 1);
        tick(); #1;
        chk("r2_rsp_done", rd_rsp_valid, 0); chk("r2_next_pop", wr_cmd_ready, 1);
        tick(); wr_cmd_valid = 0; #1;
        chk("w2_setup_psel", PSEL, 1); chk("w2_pwrite", PWRITE, 1);
        chk("w2_paddr", PADDR, 32'h34); chk("w2_pstrb", PSTRB, 4'h3);
        tick();
        tick(); #1;
        chk("w2_rsp_valid", wr_rsp_valid, 1); chk("w2_rsp_err", wr_rsp_error, 0);
        tick(); #1;
        chk("w2_rsp_done", wr_rsp_valid, 0);

        // Read timeout after eight ACCESS cycles
        tick(); rd_cmd_valid = 1; rd_cmd_addr = 32'h40; PREADY = 0; PRDATA = 32'hFFFFFFFF; #1;
        chk("to_pop", rd_cmd_ready, 1);
        tick(); rd_cmd_valid = 0;
        for (int i = 0; i < 8; i++) begin
            tick(); #1;
            chk("to_access_penable", PENABLE, 1); chk("to_access_no_rsp", rd_rsp_valid, 0);
        end
        tick(); #1;
        chk("to_rsp_valid", rd_rsp_valid, 1); chk("to_rsp_err", rd_rsp_error, 1);
        chk("to_rdata", rd_rsp_rdata, 0); chk("to_psel_drop", PSEL, 0);
        tick(); PRDATA = 32'h0; #1;
        chk("to_rsp_done", rd_rsp_valid, 0);

        // Reset in the middle of ACCESS, then a clean write
        tick(); wr_cmd_valid = 1; wr_cmd_addr = 32'h50; wr_cmd_wdata = 32'h11112222;
        wr_cmd_wstrb = 4'hF; #1;
        chk("ra_pop", wr_cmd_ready, 1);
        tick(); wr_cmd_valid = 0;
        tick();
        tick(); PRESETn = 0; #1;
        chk("ra_psel", PSEL, 0); chk("ra_penable", PENABLE, 0);
        chk("ra_paddr", PADDR, 0); chk("ra_no_rsp", wr_rsp_valid, 0);
        tick(); PRESETn = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("ra_after_wr_rsp", wr_rsp_valid, 0); chk("ra_after_rd_rsp", rd_rsp_valid, 0);
            chk("ra_after_psel", PSEL, 0);
        end
        tick(); wr_cmd_valid = 1; wr_cmd_addr = 32'h44; wr_cmd_wdata = 32'hA5A5A5A5;
        wr_cmd_wstrb = 4'hC; PREADY = 1; #1;
        chk("ra_next_pop", wr_cmd_ready, 1);
        tick(); wr_cmd_valid = 0; #1;
        chk("ra_next_setup", PSEL, 1); chk("ra_next_paddr", PADDR, 32'h44);
        chk("ra_next_pwdata", PWDATA, 32'hA5A5A5A5);
        tick();
        tick(); #1;
        chk("ra_next_rsp", wr_rsp_valid, 1); chk("ra_next_err", wr_rsp_error, 0);
        tick();

        // Round-robin with both FIFOs holding four commands
        tick(); PRESETn = 0;
        tick(); PRESETn = 1;
        wr_left = 4; rd_left = 4;
        tick();
        wr_cmd_addr = 32'h100; rd_cmd_addr = 32'h200;
        wr_cmd_valid = 1; rd_cmd_valid = 1; #1;
        for (int i = 0; i < 8; i++) begin
            exp_wr = (i % 2 == 0);
            chk("rr_wr_grant", wr_cmd_ready, exp_wr); chk("rr_rd_grant", rd_cmd_ready, !exp_wr);
            if (exp_wr) wr_left--; else rd_left--;
            tick(); wr_cmd_valid = (wr_left > 0); rd_cmd_valid = (rd_left > 0); #1;
            chk("rr_pwrite", PWRITE, exp_wr);
            chk("rr_paddr", PADDR, exp_wr ? 32'h100 : 32'h200);
            tick(); tick(); tick(); #1;
        end
        chk("rr_idle_wr", wr_cmd_ready, 0); chk("rr_idle_rd", rd_cmd_ready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
